pll_lock_sequencer: RTL and testbench

- Sequences bring-up and recovery of a PLL from a free-running reference clock: pulses PLL reset, waits for lock with a timeout, and qualifies lock stability.
- Releases the downstream system reset only after lock is qualified.
- On a lock timeout it retries a bounded number of times, then enters a sticky fault state.
- On loss of lock it counts the event and re-runs the full sequence.
- Sits beside the PLL/PLL_INIT wrapper in the board top level, clocked by the same init clock.

---
 rtl/pll_lock_sequencer.sv | 119 +++++++++++
 tb/tb_pll_lock_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL bring-up/recovery sequencer with lock timeout, bounded retry, stability qualification and sticky fault
// Ports:
//   clk_i           free-running init clock
//   rst_ni          async active-low reset
//   pll_lock_i      raw PLL lock (asynchronous, synchronized internally)
//   restart_i       single-cycle restart request, top priority
//   pll_rst_o       PLL reset, active-high
//   locked_o        qualified lock
//   sys_rst_no      downstream reset, active-low, released only while locked
//   fault_o         sticky failure flag after retries are exhausted
//   retry_cnt_o     failed attempts in the current sequence
//   lock_loss_cnt_o saturating count of lock losses since rst_ni
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT,
    localparam int MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES,
    localparam int CNT_W   = $clog2(MAX_CNT + 1),
    localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          pll_lock_i,
    input  logic          restart_i,
    output logic          pll_rst_o,
    output logic          locked_o,
    output logic          sys_rst_no,
    output logic          fault_o,
    output logic [RW-1:0] retry_cnt_o,
    output logic [7:0]    lock_loss_cnt_o
);
    typedef enum logic [2:0] {RST_PLL, WAIT_LOCK, STABLE, LOCKED, FAULT} state_e;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             sync1_q, sync2_q;
    logic             pll_rst_q, locked_q, sys_rst_n_q, fault_q;
    logic             lock_s;
    assign lock_s = sync2_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (restart_i) begin
            state_d = RST_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                RST_PLL: if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
                // lock is tested before the timeout so a lock on the final cycle wins
                WAIT_LOCK: if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = (retry_q < RW'(MAX_RETRIES)) ? RST_PLL : FAULT;
                    retry_d = (retry_q < RW'(MAX_RETRIES)) ? retry_q + 1'b1 : retry_q;
                end
                // a dropout restarts the lock wait without consuming a retry
                STABLE: if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                    retry_d = '0;
                end
                LOCKED: begin
                    cnt_d = '0;
                    if (!lock_s) begin
                        state_d = RST_PLL;
                        loss_d  = loss_q + {7'd0, loss_q != 8'hFF};
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end
    // outputs are decoded from the next state so they move on the same edge as the state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RST_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            pll_rst_q   <= 1'b1;
            locked_q    <= 1'b0;
            sys_rst_n_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            sync1_q     <= pll_lock_i;
            sync2_q     <= sync1_q;
            pll_rst_q   <= (state_d == RST_PLL) || (state_d == FAULT);
            locked_q    <= state_d == LOCKED;
            sys_rst_n_q <= state_d == LOCKED;
            fault_q     <= state_d == FAULT;
        end
    end
    assign pll_rst_o       = pll_rst_q;
    assign locked_o        = locked_q;
    assign sys_rst_no      = sys_rst_n_q;
    assign fault_o         = fault_q;
    assign retry_cnt_o     = retry_q;
    assign lock_loss_cnt_o = loss_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, locked, sys_rst_n, fault;
    logic [1:0] retry;
    logic [7:0] loss;
    int         checks = 0;
    int         errors = 0;
    int         n;
    int         timeouts = 0;
    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .pll_lock_i     (lock),
        .restart_i      (restart),
        .pll_rst_o      (pll_rst),
        .locked_o       (locked),
        .sys_rst_no     (sys_rst_n),
        .fault_o        (fault),
        .retry_cnt_o    (retry),
        .lock_loss_cnt_o(loss)
    );
    initial forever #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask
    function automatic logic sig(input int sel);
        return (sel == 0) ? pll_rst : (sel == 1) ? locked : fault;
    endfunction
    // negedges until the selected output (0 pll_rst, 1 locked, 2 fault) equals val; -1 on timeout
    task automatic wait_for(input int sel, input logic val, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (sig(sel) !== val && cnt < 200);
        if (sig(sel) !== val) cnt = -1;
    endtask
    task automatic pulse_restart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
    endtask
    initial begin
        #1 rst_n = 1'b0;
        tick(2);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_locked", locked, 0);
        check("rst_sys_rst_n", sys_rst_n, 0);
        check("rst_fault", fault, 0);
        check("rst_retry", retry, 0);
        check("rst_loss", loss, 0);
        // 1: clean lock; 11 = 2 sync edges + 1 WAIT_LOCK decision + 8 stable cycles
        rst_n = 1'b1;
        wait_for(0, 1'b0, n);
        check("s1_rst_len", n, 4);
        tick(9);
        lock = 1'b1;
        wait_for(1, 1'b1, n);
        check("s1_lock_lat", n, 11);
        check("s1_sys_rst_n", sys_rst_n, 1);
        check("s1_pll_rst", pll_rst, 0);
        check("s1_retry", retry, 0);
        // 2: restart from LOCKED, then a one-cycle dropout inside STABLE
        lock = 1'b0;
        pulse_restart();
        check("s2_restart_pll_rst", pll_rst, 1);
        check("s2_restart_locked", locked, 0);
        check("s2_restart_no_loss", loss, 0);
        wait_for(0, 1'b0, n);
        check("s2_rst_len", n, 4);
        lock = 1'b1;
        tick(5);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        check("s2_not_locked", locked, 0);
        wait_for(1, 1'b1, n);
        check("s2_relock_lat", n, 11);
        check("s2_retry", retry, 0);
        // 3: no lock -> timeouts, retries 1 and 2, then FAULT
        lock = 1'b0;
        pulse_restart();
        wait_for(0, 1'b0, n);
        check("s3_rst_len0", n, 4);
        wait_for(0, 1'b1, n);
        check("s3_timeout1", n, 32);
        check("s3_retry1", retry, 1);
        wait_for(0, 1'b0, n);
        check("s3_rst_len1", n, 4);
        wait_for(0, 1'b1, n);
        check("s3_timeout2", n, 32);
        check("s3_retry2", retry, 2);
        wait_for(0, 1'b0, n);
        check("s3_rst_len2", n, 4);
        wait_for(2, 1'b1, n);
        check("s3_timeout3_fault", n, 32);
        check("s3_fault_pll_rst", pll_rst, 1);
        check("s3_fault_retry", retry, 2);
        check("s3_fault_sys_rst_n", sys_rst_n, 0);
        lock = 1'b1;
        tick(40);
        check("s3_fault_sticky", fault, 1);
        check("s3_fault_pll_held", pll_rst, 1);
        check("s3_fault_locked", locked, 0);
        // 4: restart out of FAULT then a clean lock
        lock = 1'b0;
        pulse_restart();
        check("s4_fault_clr", fault, 0);
        check("s4_retry_clr", retry, 0);
        check("s4_pll_rst", pll_rst, 1);
        wait_for(0, 1'b0, n);
        check("s4_rst_len", n, 4);
        tick(9);
        lock = 1'b1;
        wait_for(1, 1'b1, n);
        check("s4_lock_lat", n, 11);
        check("s4_sys_rst_n", sys_rst_n, 1);
        check("s4_loss_before", loss, 0);
        // 5: lock loss: 3 = 2 sync edges + 1 LOCKED decision
        lock = 1'b0;
        wait_for(1, 1'b0, n);
        check("s5_loss_lat", n, 3);
        check("s5_sys_rst_n", sys_rst_n, 0);
        check("s5_pll_rst", pll_rst, 1);
        check("s5_loss1", loss, 1);
        for (int i = 2; i <= 300; i++) begin
            lock = 1'b1;
            wait_for(1, 1'b1, n);
            if (n < 0) timeouts++;
            lock = 1'b0;
            wait_for(1, 1'b0, n);
            if (n < 0) timeouts++;
            if (i == 254) check("s5_loss254", loss, 254);
            if (i == 255) check("s5_loss255", loss, 255);
        end
        check("s5_loop_timeouts", timeouts, 0);
        check("s5_loss_sat", loss, 255);
        // 6a: async reset while in STABLE (RST 4 + WAIT 1 -> STABLE, 8 cycles in is mid-STABLE)
        lock = 1'b1;
        tick(8);
        check("s6_pre_pll_rst", pll_rst, 0);
        check("s6_pre_locked", locked, 0);
        #2 rst_n = 1'b0;
        lock = 1'b0;
        #1;
        check("s6_async_pll_rst", pll_rst, 1);
        check("s6_async_locked", locked, 0);
        check("s6_async_sys_rst_n", sys_rst_n, 0);
        check("s6_async_fault", fault, 0);
        check("s6_async_retry", retry, 0);
        check("s6_async_loss", loss, 0);
        // 6b: lock_s rises on the cycle the wait counter reaches 31
        tick(2);
        rst_n = 1'b1;
        wait_for(0, 1'b0, n);
        check("s6_rst_len", n, 4);
        tick(29);
        lock = 1'b1;
        tick(3);
        check("s6_tie_pll_rst", pll_rst, 0);
        check("s6_tie_retry", retry, 0);
        check("s6_tie_fault", fault, 0);
        wait_for(1, 1'b1, n);
        check("s6_tie_lock_lat", n, 8);
        check("s6_tie_retry_final", retry, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
